// File: rtl/luma4x4_mode_decision.sv
// Intra 4x4 luma mode decision: latches eight residual blocks, scans them by SAD one per cycle,
// and reports the cheapest enabled mode with its cost and residual block after a fixed 9-cycle latency.
module luma4x4_mode_decision (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       mode_avail,
    input  logic [15:0][7:0] vres,
    input  logic [15:0][7:0] hres,
    input  logic [15:0][7:0] vlres,
    input  logic [15:0][7:0] vrres,
    input  logic [15:0][7:0] hures,
    input  logic [15:0][7:0] hdres,
    input  logic [15:0][7:0] ddlres,
    input  logic [15:0][7:0] ddrres,
    output logic             busy,
    output logic             done,
    output logic [3:0]       best_mode,
    output logic [11:0]      best_sad,
    output logic [15:0][7:0] best_res
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0][7:0] blk_q [8];
    logic [7:0]       avail_q;
    logic [2:0]       idx_q;
    logic             none_q;
    logic [3:0]       run_mode_q;
    logic [11:0]      run_sad_q;
    logic [15:0][7:0] run_res_q;
    logic             done_q;
    logic [3:0]       best_mode_q;
    logic [11:0]      best_sad_q;
    logic [15:0][7:0] best_res_q;

    logic [15:0][7:0] cur_blk;
    logic [11:0]      cur_sad;
    logic             take;
    logic             accept;

    // Two's-complement magnitude in 9 bits so that -128 maps to 128.
    function automatic logic [8:0] abs8(input logic [7:0] b);
        logic [8:0] ext;
        ext = {b[7], b};
        return b[7] ? (9'd0 - ext) : ext;
    endfunction

    // Evaluation index to H.264 intra4x4 mode number (mode 2 is DC, not handled here).
    function automatic logic [3:0] mode_of(input logic [2:0] idx);
        logic [3:0] m;
        case (idx)
            3'd0:    m = 4'd0;
            3'd1:    m = 4'd1;
            3'd2:    m = 4'd3;
            3'd3:    m = 4'd4;
            3'd4:    m = 4'd5;
            3'd5:    m = 4'd6;
            3'd6:    m = 4'd7;
            default: m = 4'd8;
        endcase
        return m;
    endfunction

    assign accept  = (state_q == ST_IDLE) && start;
    assign cur_blk = blk_q[idx_q];

    always_comb begin
        cur_sad = 12'd0;
        for (int i = 0; i < 16; i++) begin
            cur_sad = cur_sad + {3'b000, abs8(cur_blk[i])};
        end
    end

    // The none-found flag forces the first enabled mode in, independent of the 12'hFFF seed.
    assign take = avail_q[idx_q] && (none_q || (cur_sad < run_sad_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_EVAL;
            ST_EVAL: if (idx_q == 3'd7) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                blk_q[k] <= '0;
            end
            avail_q    <= '0;
            idx_q      <= '0;
            none_q     <= 1'b0;
            run_mode_q <= '0;
            run_sad_q  <= '0;
            run_res_q  <= '0;
        end else if (accept) begin
            // Storage order follows evaluation order, not port order.
            blk_q[0]   <= vres;
            blk_q[1]   <= hres;
            blk_q[2]   <= ddlres;
            blk_q[3]   <= ddrres;
            blk_q[4]   <= vrres;
            blk_q[5]   <= hdres;
            blk_q[6]   <= vlres;
            blk_q[7]   <= hures;
            avail_q    <= mode_avail;
            idx_q      <= 3'd0;
            none_q     <= 1'b1;
            run_mode_q <= 4'hF;
            run_sad_q  <= 12'hFFF;
            run_res_q  <= '0;
        end else if (state_q == ST_EVAL) begin
            idx_q <= idx_q + 3'd1;
            if (take) begin
                none_q     <= 1'b0;
                run_mode_q <= mode_of(idx_q);
                run_sad_q  <= cur_sad;
                run_res_q  <= cur_blk;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            best_res_q  <= '0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                best_mode_q <= run_mode_q;
                best_sad_q  <= run_sad_q;
                best_res_q  <= run_res_q;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
    assign best_res  = best_res_q;

endmodule

// File: tb/tb_luma4x4_mode_decision.sv
// Scoreboard bench for luma4x4_mode_decision: a driver pushes model results, a monitor checks each done.
module tb_luma4x4_mode_decision;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [7:0]       mode_avail;
    logic [15:0][7:0] blk [8];
    logic             busy, done;
    logic [3:0]       best_mode;
    logic [11:0]      best_sad;
    logic [15:0][7:0] best_res;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]   mode;
        logic [11:0]  sad;
        logic [127:0] res;
        int           e0;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    // Block index k follows evaluation order V,H,DDL,DDR,VR,HD,VL,HU.
    luma4x4_mode_decision dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode_avail (mode_avail),
        .vres       (blk[0]),
        .hres       (blk[1]),
        .ddlres     (blk[2]),
        .ddrres     (blk[3]),
        .vrres      (blk[4]),
        .hdres      (blk[5]),
        .vlres      (blk[6]),
        .hures      (blk[7]),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .best_res   (best_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sum of absolute values per block, cheapest enabled block wins, earlier wins ties.
    function automatic exp_t model(input logic [7:0] av);
        exp_t e;
        int   modes [8] = '{0, 1, 3, 4, 5, 6, 7, 8};
        int   best  = -1;
        e.mode = 4'hF;
        e.sad  = 12'hFFF;
        e.res  = '0;
        e.e0   = 0;
        for (int k = 0; k < 8; k++) begin
            int s = 0;
            for (int i = 0; i < 16; i++) begin
                int v = int'($signed(blk[k][i]));
                s += (v < 0) ? -v : v;
            end
            if (av[k] && (best < 0 || s < best)) begin
                best   = s;
                e.mode = 4'(modes[k]);
                e.sad  = 12'(s);
                e.res  = blk[k];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("best_mode", best_mode, e.mode);
                chk("best_sad", best_sad, e.sad);
                chk("best_res", best_res, e.res);
                chk("latency", cyc - e.e0, 9);
                chk("busy_at_done", busy, 0);
                last_exp = e;
            end
        end
    end

    task automatic fill_const(input int k, input logic [7:0] v);
        for (int i = 0; i < 16; i++) blk[k][i] = v;
    endtask

    task automatic fill_rand(input bit narrow);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 16; i++)
                blk[k][i] = narrow ? 8'($urandom_range(0, 2)) - 8'd1 : 8'($urandom);
    endtask

    // Caller must be between a falling and the next rising edge.
    task automatic issue(input logic [7:0] av, input bit expect_result);
        exp_t e;
        mode_avail = av;
        start      = 1'b1;
        e          = model(av);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.e0  = cyc;
        if (expect_result) sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("hold_mode", best_mode, last_exp.mode);
                chk("hold_sad", best_sad, last_exp.sad);
                return;
            end
        end
        chk("done_timeout", 1, 0);
        sb.delete();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        mode_avail = 8'h00;
        for (int k = 0; k < 8; k++) fill_const(k, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mode", best_mode, 0);
        chk("rst_sad", best_sad, 0);
        chk("rst_res", best_res, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;

        // All zero: tie resolved to V.
        issue(8'hFF, 1);
        wait_done();

        // DDR is cheapest (32) against V (80) and the rest (160); issued on the done cycle.
        for (int k = 0; k < 8; k++) fill_const(k, 8'd10);
        fill_const(0, 8'd5);
        fill_const(3, 8'hFE);
        issue(8'hFF, 1);
        wait_done();

        // Only HU enabled, maximum possible cost.
        for (int k = 0; k < 8; k++) fill_const(k, 8'd127);
        fill_const(7, 8'h80);
        issue(8'h80, 1);
        wait_done();

        // Nothing enabled.
        issue(8'h00, 1);
        wait_done();

        // Restart while busy with altered inputs: ignored, latched copy used.
        fill_rand(0);
        issue(8'hFF, 1);
        fill_rand(0);
        mode_avail = 8'h01;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fill_rand(1);
        wait_done();
        chk("busy_after_done", busy, 0);

        // Randomised transactions, some with small magnitudes to provoke ties.
        for (int t = 0; t < 40; t++) begin
            fill_rand(t % 3 == 0);
            issue((t % 7 == 0) ? 8'h00 : 8'($urandom), 1);
            wait_done();
        end

        // Reset mid-EVAL at E4: aborts with no done and clears outputs.
        fill_rand(0);
        issue(8'hFF, 0);
        repeat (4) @(posedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mode", best_mode, 0);
        chk("abort_sad", best_sad, 0);
        chk("abort_res", best_res, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("no_done_after_abort_mode", best_mode, 0);

        for (int k = 0; k < 8; k++) fill_const(k, 8'd10);
        fill_const(0, 8'd5);
        fill_const(3, 8'hFE);
        issue(8'hFF, 1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
